bfly_in_buf: RTL

- Input pairing buffer directly upstream of the radix-2 butterfly stage in the 16-lane parallel FFT datapath.
- Accepts a frame of 2*DEPTH input beats, each LANES complex samples wide.
- Holds the first half of the frame in a DEPTH-deep shift register. During the second half it presents each new beat (din1) together with the beat DEPTH positions earlier (din2), and asserts bfly_en to the butterfly.

---
 rtl/bfly_in_buf_if.sv | 24 ++
 rtl/bfly_in_buf.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bfly_in_buf_if.sv
// Beat stream into the butterfly pairing buffer and the paired beats it hands on.
interface bfly_in_buf_if #(
    parameter int WIDTH = 9,
    parameter int LANES = 16
);
    logic                                 din_valid;
    logic signed [0:LANES-1][WIDTH-1:0]   din_i;
    logic signed [0:LANES-1][WIDTH-1:0]   din_q;
    logic                                 bfly_en;
    logic                                 frame_done;
    logic signed [0:LANES-1][WIDTH-1:0]   din1_i;
    logic signed [0:LANES-1][WIDTH-1:0]   din1_q;
    logic signed [0:LANES-1][WIDTH-1:0]   din2_i;
    logic signed [0:LANES-1][WIDTH-1:0]   din2_q;

    modport master (
        output din_valid, din_i, din_q,
        input  bfly_en, frame_done, din1_i, din1_q, din2_i, din2_q
    );
    modport slave (
        input  din_valid, din_i, din_q,
        output bfly_en, frame_done, din1_i, din1_q, din2_i, din2_q
    );
endinterface

// File: rtl/bfly_in_buf.sv
// Radix-2 input pairing buffer: stores the first half-frame and pairs each
// second-half beat with the beat DEPTH positions earlier.
module bfly_lane #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             fill,
    input  logic             load,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] in_q,
    output logic [WIDTH-1:0] d1_i,
    output logic [WIDTH-1:0] d1_q,
    output logic [WIDTH-1:0] d2_i,
    output logic [WIDTH-1:0] d2_q
);
    logic [DEPTH-1:0][WIDTH-1:0] sr_i, sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_i <= '0;
            sr_q <= '0;
            d1_i <= '0;
            d1_q <= '0;
            d2_i <= '0;
            d2_q <= '0;
        end else begin
            // while pairing, zeros trail in so the register is empty at frame end
            if (shift) begin
                sr_i <= {sr_i[DEPTH-2:0], fill ? in_i : {WIDTH{1'b0}}};
                sr_q <= {sr_q[DEPTH-2:0], fill ? in_q : {WIDTH{1'b0}}};
            end
            if (load) begin
                d1_i <= in_i;
                d1_q <= in_q;
                d2_i <= sr_i[DEPTH-1];
                d2_q <= sr_q[DEPTH-1];
            end
        end
    end
endmodule

module bfly_in_buf #(
    parameter int SIG   = 1,
    parameter int INT   = 2,
    parameter int FLT   = 6,
    parameter int WIDTH = SIG + INT + FLT,
    parameter int LANES = 16,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    bfly_in_buf_if.slave  bus,
    output logic          state_o
);
    localparam int            CW   = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept, fill_sel, pair_fire, last_fire;

    assign accept = bus.din_valid & ~flush;

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = FILL;
        else if (accept && cnt == LAST)
            state_nxt = (state == FILL) ? PAIR : FILL;
    end

    always_comb begin
        fill_sel  = (state == FILL);
        pair_fire = accept & (state == PAIR);
        last_fire = pair_fire & (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            bus.bfly_en    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            if (flush)       cnt <= '0;
            else if (accept) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            bus.bfly_en    <= pair_fire;
            bus.frame_done <= last_fire;
        end
    end

    assign state_o = state;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [WIDTH-1:0] d1_i, d1_q, d2_i, d2_q;

        bfly_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .shift(accept),
            .fill (fill_sel),
            .load (pair_fire),
            .in_i (bus.din_i[j]),
            .in_q (bus.din_q[j]),
            .d1_i (d1_i),
            .d1_q (d1_q),
            .d2_i (d2_i),
            .d2_q (d2_q)
        );

        assign bus.din1_i[j] = d1_i;
        assign bus.din1_q[j] = d1_q;
        assign bus.din2_i[j] = d2_i;
        assign bus.din2_q[j] = d2_q;
    end
endmodule
